dm_multiport: RTL

Parametrised multi-channel data memory that succeeds the single-port DM. It sits between the data-address generators / bus-connect (bc) path and the DM array, and serves up to NUM_CH independent read/write channels per cycle. The array is split into 2**BANK_BITS low-order-interleaved banks, with per-bank arbitration and a stall output for conflicts. Writes commit at execute+1, and reads forward pending write data.

---
 rtl/dm_multiport.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dm_multiport.sv
// dm_multiport: multi-channel, bank-interleaved data memory.
// Each cycle up to NUM_CH channels request a read or write. Banks are selected
// by the low address bits, and the lowest-index channel wins each bank.
// Writes are latched into a per-channel pending slot and commit one cycle later
// with the bc_dt data. Reads forward data from writes that commit in the same cycle.
module dm_multiport #(
  parameter int DMA_SIZE  = 17,
  parameter int DMD_SIZE  = 16,
  parameter int NUM_CH    = 2,
  parameter int BANK_BITS = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ps_dm_cslt,
  input  logic [NUM_CH-1:0]            ps_dm_wrb,
  input  logic [NUM_CH*DMA_SIZE-1:0]   dg_dm_add,
  input  logic [NUM_CH*DMD_SIZE-1:0]   bc_dt,
  output logic [NUM_CH*DMD_SIZE-1:0]   dm_bc_dt,
  output logic [NUM_CH-1:0]            dm_rd_vld,
  output logic                         dm_stall
);

  localparam int DEPTH = 2 ** DMA_SIZE;
  // Address bits that select the bank. With BANK_BITS=0 the mask is zero,
  // so every access falls into the same single bank.
  localparam logic [DMA_SIZE-1:0] BANK_MASK = DMA_SIZE'((1 << BANK_BITS) - 1);

  logic [DMD_SIZE-1:0] mem [DEPTH];

  logic [DMA_SIZE-1:0] add_w   [NUM_CH];
  logic [DMD_SIZE-1:0] wdat_w  [NUM_CH];
  logic [DMD_SIZE-1:0] fwd_dat [NUM_CH];
  logic [NUM_CH-1:0]   fwd_hit;

  logic [NUM_CH-1:0]   active;
  logic [NUM_CH-1:0]   grant;
  logic [NUM_CH-1:0]   served_q, served_d;

  logic [NUM_CH-1:0]   pend_vld_q;
  logic [DMA_SIZE-1:0] pend_add_q [NUM_CH];

  logic [DMD_SIZE-1:0] rd_dat_q [NUM_CH];
  logic [NUM_CH-1:0]   rd_vld_q;

  // Unpack the per-channel buses and repack the read data.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign add_w[gi]                         = dg_dm_add[gi*DMA_SIZE +: DMA_SIZE];
    assign wdat_w[gi]                        = bc_dt[gi*DMD_SIZE +: DMD_SIZE];
    assign dm_bc_dt[gi*DMD_SIZE +: DMD_SIZE] = rd_dat_q[gi];
  end

  assign dm_rd_vld = rd_vld_q;

  // Channels already served earlier in a stalled sequence stay out of arbitration.
  assign active = ps_dm_cslt & ~served_q;

  // Per-bank priority arbitration: a lower-index active channel on the same bank blocks.
  always_comb begin
    grant = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      grant[c] = active[c];
      for (int j = 0; j < c; j++) begin
        if (active[j] && (((add_w[j] ^ add_w[c]) & BANK_MASK) == '0)) begin
          grant[c] = 1'b0;
        end
      end
    end
  end

  // Stall while any active request lost. The served mask accumulates during a
  // stall and clears on the first cycle that does not stall.
  always_comb begin
    dm_stall = !rst && ((active & ~grant) != '0);
    served_d = dm_stall ? (served_q | grant) : '0;
  end

  // Forward from pending writes that commit this cycle; scanning in ascending
  // order lets the highest-index matching channel win.
  always_comb begin
    fwd_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      fwd_dat[c] = '0;
      for (int w = 0; w < NUM_CH; w++) begin
        if (pend_vld_q[w] && (pend_add_q[w] == add_w[c])) begin
          fwd_hit[c] = 1'b1;
          fwd_dat[c] = wdat_w[w];
        end
      end
    end
  end

  // Control state, pending-write slots and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      served_q   <= '0;
      pend_vld_q <= '0;
      rd_vld_q   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        rd_dat_q[c]   <= '0;
        pend_add_q[c] <= '0;
      end
    end else begin
      served_q <= served_d;
      for (int c = 0; c < NUM_CH; c++) begin
        pend_vld_q[c] <= grant[c] & ps_dm_wrb[c];
        rd_vld_q[c]   <= grant[c] & ~ps_dm_wrb[c];
        if (grant[c] && ps_dm_wrb[c]) begin
          pend_add_q[c] <= add_w[c];
        end
        if (grant[c] && !ps_dm_wrb[c]) begin
          rd_dat_q[c] <= fwd_hit[c] ? fwd_dat[c] : mem[add_w[c]];
        end
      end
    end
  end

  // Array write port. Reset drops a write whose data phase coincides with it.
  // Contents are never cleared by reset.
  always_ff @(posedge clk) begin
    for (int w = 0; w < NUM_CH; w++) begin
      if (!rst && pend_vld_q[w]) begin
        mem[pend_add_q[w]] <= wdat_w[w];
      end
    end
  end

endmodule
